mux_arb_n: RTL
==============

Name: mux_arb_n

Overview:
- Parametrised N-channel registered selector: generalises the plain 2:1 data mux to NUM_CH sources of DATA_W bits each.
- Each source has a valid/ready handshake. The block arbitrates among them and presents one winner per cycle through a single-entry output register.
- Sits in the CPU pipeline wherever several producers share one consumer, e.g. writeback source select or request merge in front of the memory bus.

Parameters:
- NUM_CH, 4, number of input channels (>=1).
- DATA_W, 32, payload width per channel.
- SEL_W, derived localparam = max(1, clog2(NUM_CH)), width of the channel index. Not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush; drops the held output entry.
- in_valid  input  NUM_CH  per-channel request valid.
- in_data  input  NUM_CH*DATA_W  packed payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- in_ready  output  NUM_CH  per-channel accept. Combinational; at most one bit high.
- out_valid  output  1  output register holds an entry.
- out_data  output  DATA_W  registered winner payload.
- out_sel  output  SEL_W  registered index of the winning channel.
- out_ready  input  1  consumer accepts the output entry.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rstn).
- Reset values: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0.
- Reset asserted mid-transfer drops the held entry immediately.
- Load enable: load = ~flush & (~out_valid | out_ready).
- Grant:
  - grant = one-hot arbitration result over in_valid (see Optional Feature).
  - in_ready[i] = load & grant[i].
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
- Output register update:
  - Cycle after a transfer: out_valid=1, out_data=in_data[i], out_sel=i.
  - If load=1 and no in_valid bit is set: out_valid=0; out_data and out_sel hold their old values.
  - Latency is 1 cycle from input handshake to out_valid. Full throughput: one transfer per cycle while out_ready=1.
- Backpressure: out_valid=1 with out_ready=0 means all in_ready=0, and out_data/out_sel are held stable.
- Flush:
  - Next cycle out_valid=0. No grant in the flush cycle. ptr unchanged.
  - flush has priority over a simultaneous out_ready handshake: the entry counts as dropped, not delivered.
- ptr update: only on a transfer, ptr <= (i==NUM_CH-1) ? 0 : i+1. No update when nothing is granted.
- NUM_CH=1: degenerates to a one-entry pipeline register. out_sel is always 0.
- Inputs are not required to stay stable before being granted. A channel may drop in_valid without penalty.

Optional Feature:
- Macro MUX_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at ptr, wraps modulo NUM_CH, and the first set in_valid wins. ptr updates as above.
- Undefined: fixed priority, lowest index wins. ptr is not implemented; its logic is removed.
- All ports are identical in both builds.

Test Plan:
- Reset: hold rstn=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 while in reset. First cycle after release grants ch0 -> out_sel=0, out_data=in_data[0].
- RR fairness (macro on): in_valid=4'b1111 held, out_ready=1, data_i=32'hA0+i -> out_sel sequence 0,1,2,3,0 on consecutive cycles. Each in_ready[i] pulses exactly once per 4 cycles.
- Fixed priority (macro off): same stimulus -> out_sel=0 every cycle, in_ready=4'b0001 every cycle.
- Backpressure: ch2 valid with data 32'hDEADBEEF, out_ready=0 for 3 cycles -> out_valid=1 and out_data=32'hDEADBEEF stable, in_ready=0. Raise out_ready -> next pending channel is granted in the same cycle.
- Flush collision: out_valid=1, out_ready=1, flush=1, in_valid=4'b0100 -> in_ready=0 that cycle; next cycle out_valid=0; ptr unchanged, so ch2 is granted the following cycle.
- Wrap/idle: macro on, grant ch3 then in_valid=0 for 2 cycles, then in_valid=4'b1001 -> ch0 wins (ptr wrapped to 0); out_valid=0 during the idle cycles.

Source files
------------

// File: rtl/mux_arb_n.sv
// mux_arb_n: NUM_CH-way valid/ready arbiter feeding a single-entry output register.
// Define MUX_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module mux_arb_n #(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 32,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    logic              load;
    logic              any_vld;
    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  gsel;
    logic [DATA_W-1:0] gdata;

    assign any_vld = |in_valid;
    assign load    = ~flush & (~out_valid | out_ready);

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0] ptr;

    // Scan from ptr upward, wrapping; the first requester found wins.
    always_comb begin
        logic found;
        int   j;
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!found && in_valid[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            ptr <= '0;
        else if (load && any_vld)
            ptr <= (gsel == SEL_W'(NUM_CH - 1)) ? '0 : gsel + SEL_W'(1);
    end
`else
    // Isolate the lowest set request bit.
    assign grant = in_valid & (~in_valid + NUM_CH'(1));
`endif

    always_comb begin
        gsel  = '0;
        gdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gsel  = gsel | SEL_W'(i);
                gdata = gdata | in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Held low during reset so no producer sees an accept it cannot complete.
    assign in_ready = (rstn && load) ? grant : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= any_vld;
            if (any_vld) begin
                out_data <= gdata;
                out_sel  <= gsel;
            end
        end
    end

endmodule
